// File: rtl/decompressor_stream_sequencer_if.sv
// Byte-stream input and item output handshakes of decompressor_stream_sequencer.
// slave = sequencer side, master = stream producer / decompressor side.
interface decompressor_stream_sequencer_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] data_in;
    logic        control_word_in;
    logic        data_in_valid;
    logic        decompressor_busy;

    modport slave (
        input  in_byte, in_valid, in_last, decompressor_busy,
        output in_ready, data_in, control_word_in, data_in_valid
    );
    modport master (
        output in_byte, in_valid, in_last, decompressor_busy,
        input  in_ready, data_in, control_word_in, data_in_valid
    );
endinterface

// File: rtl/decompressor_stream_sequencer.sv
// LZRW1 group unpacker feeding decompressor_top one 16-bit item at a time.
// Optional macro STATS_EN adds saturating literal/copy counters.
module decompressor_stream_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic abort,
    decompressor_stream_sequencer_if.slave s,
    output logic stream_done,
    output logic stream_error
`ifdef STATS_EN
    ,
    output logic [CNT_W-1:0] literal_count,
    output logic [CNT_W-1:0] copy_count
`endif
);

    typedef enum logic [2:0] {
        IDLE, CTRL, FETCH_HI, FETCH_LO, ISSUE, GAP, DONE, ERR
    } state_t;

    typedef struct packed {
        logic        cw;
        logic [15:0] data;
    } item_t;

    state_t     state_q, state_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic [2:0] idx_q, idx_d;
    item_t      item_q, item_d;
    logic       last_q, last_d;
    logic       err_q, err_d;

    logic byte_xfer;
    logic accept;
    logic flag;

    assign s.in_ready        = (state_q == CTRL) || (state_q == FETCH_HI) || (state_q == FETCH_LO);
    assign s.data_in_valid   = (state_q == ISSUE);
    assign s.data_in         = item_q.data;
    assign s.control_word_in = item_q.cw;
    assign stream_done       = (state_q == DONE);
    assign stream_error      = err_q;

    assign byte_xfer = s.in_valid && s.in_ready;
    assign accept    = (state_q == ISSUE) && !s.decompressor_busy;
    // Flags are consumed MSB first: item k uses C[7-k].
    assign flag      = ctrl_q[3'd7 - idx_q];

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        idx_d   = idx_q;
        item_d  = item_q;
        last_d  = last_q;
        err_d   = err_q;
        if (abort) begin
            state_d = IDLE;
            ctrl_d  = 8'h00;
            idx_d   = 3'd0;
            item_d  = '0;
            last_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = CTRL;
                CTRL: begin
                    if (byte_xfer) begin
                        ctrl_d  = s.in_byte;
                        idx_d   = 3'd0;
                        state_d = s.in_last ? DONE : FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (byte_xfer) begin
                        if (!flag) begin
                            item_d  = '{cw: 1'b0, data: {8'h00, s.in_byte}};
                            last_d  = s.in_last;
                            state_d = ISSUE;
                        end else if (s.in_last) begin
                            // Stream ended between the two bytes of a copy.
                            err_d   = 1'b1;
                            state_d = ERR;
                        end else begin
                            item_d.data[15:8] = s.in_byte;
                            state_d = FETCH_LO;
                        end
                    end
                end
                FETCH_LO: begin
                    if (byte_xfer) begin
                        item_d.data[7:0] = s.in_byte;
                        item_d.cw        = 1'b1;
                        last_d           = s.in_last;
                        state_d          = ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        if (last_q)             state_d = DONE;
                        else if (idx_q == 3'd7) state_d = CTRL;
                        else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = GAP;
                        end
                    end
                end
                // One idle cycle lets the decompressor raise busy before the next item.
                GAP:  state_d = FETCH_HI;
                DONE: begin
                    last_d  = 1'b0;
                    state_d = IDLE;
                end
                ERR:  state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ctrl_q  <= 8'h00;
            idx_q   <= 3'd0;
            item_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            idx_q   <= idx_d;
            item_q  <= item_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

`ifdef STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] lit_cnt_q, lit_cnt_d;
    logic [CNT_W-1:0] cp_cnt_q, cp_cnt_d;

    always_comb begin
        lit_cnt_d = lit_cnt_q;
        cp_cnt_d  = cp_cnt_q;
        if (abort) begin
            lit_cnt_d = '0;
            cp_cnt_d  = '0;
        end else if (accept) begin
            if (item_q.cw) begin
                if (!(&cp_cnt_q)) cp_cnt_d = cp_cnt_q + CNT_ONE;
            end else begin
                if (!(&lit_cnt_q)) lit_cnt_d = lit_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lit_cnt_q <= '0;
            cp_cnt_q  <= '0;
        end else begin
            lit_cnt_q <= lit_cnt_d;
            cp_cnt_q  <= cp_cnt_d;
        end
    end

    assign literal_count = lit_cnt_q;
    assign copy_count    = cp_cnt_q;
`endif

endmodule
